// File: rtl/denoise_pkg.sv
// Shared definitions for the temporal denoise core: default geometry,
// the mode-0 constant pattern and the output mode encodings.
package denoise_pkg;

    localparam int CH_WIDTH_DEF = 8;
    localparam int CHANNELS_DEF = 3;
    localparam int ALPHA_W_DEF  = 4;

    localparam logic [CHANNELS_DEF*CH_WIDTH_DEF-1:0] TEST_PATTERN_DEF = 24'hFF0000;

    typedef enum logic [1:0] {
        MODE_PATTERN = 2'b00,
        MODE_PASS    = 2'b01,
        MODE_BLEND   = 2'b10,
        MODE_DIFF    = 2'b11
    } mode_e;

endpackage

// File: rtl/denoise_blend_ch.sv
// One colour channel of the denoise datapath: S2 computes the signed
// prev-curr difference and motion flag, S3 blends/selects into the output flop.
module denoise_blend_ch
    import denoise_pkg::*;
#(
    parameter int CH_WIDTH = CH_WIDTH_DEF,
    parameter int ALPHA_W  = ALPHA_W_DEF
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                ld2,
    input  logic                ld3,
    input  logic [CH_WIDTH-1:0] prev_c,
    input  logic [CH_WIDTH-1:0] curr_c,
    input  logic [CH_WIDTH-1:0] thresh,
    input  logic [CH_WIDTH-1:0] pat_c,
    input  mode_e               mode,
    input  logic [ALPHA_W-1:0]  alpha,
    output logic [CH_WIDTH-1:0] out_c
);

    // Wide enough for curr + diff*alpha before the shift, plus a sign bit.
    localparam int SW = CH_WIDTH + ALPHA_W + 2;

    logic signed [CH_WIDTH:0] diff_n, abs_n, diff_d, diff_q;
    logic [CH_WIDTH-1:0]      absd_d, absd_q, curr2_d, curr2_q;
    logic                     motion_d, motion_q;
    logic signed [SW-1:0]     prod, shifted, sum;
    logic [CH_WIDTH-1:0]      blend, sel, out_d, out_q;

    always_comb begin
        diff_n   = $signed({1'b0, prev_c}) - $signed({1'b0, curr_c});
        abs_n    = diff_n[CH_WIDTH] ? -diff_n : diff_n;
        diff_d   = ld2 ? diff_n : diff_q;
        absd_d   = ld2 ? (abs_n[CH_WIDTH] ? '1 : abs_n[CH_WIDTH-1:0]) : absd_q;
        motion_d = ld2 ? (abs_n > $signed({1'b0, thresh})) : motion_q;
        curr2_d  = ld2 ? curr_c : curr2_q;

        // >>> on a signed product floors toward minus infinity.
        prod    = SW'(diff_q) * SW'($signed({1'b0, alpha}));
        shifted = prod >>> ALPHA_W;
        sum     = $signed(SW'({1'b0, curr2_q})) + shifted;
        if (sum[SW-1]) begin
            blend = '0;
        end else if (sum[SW-2:CH_WIDTH] != '0) begin
            blend = '1;
        end else begin
            blend = sum[CH_WIDTH-1:0];
        end

        case (mode)
            MODE_PATTERN: sel = pat_c;
            MODE_PASS:    sel = curr2_q;
            MODE_BLEND:   sel = motion_q ? curr2_q : blend;
            MODE_DIFF:    sel = absd_q;
            default:      sel = curr2_q;
        endcase
        out_d = ld3 ? sel : out_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            diff_q   <= '0;
            absd_q   <= '0;
            motion_q <= 1'b0;
            curr2_q  <= '0;
            out_q    <= '0;
        end else begin
            diff_q   <= diff_d;
            absd_q   <= absd_d;
            motion_q <= motion_d;
            curr2_q  <= curr2_d;
            out_q    <= out_d;
        end
    end

    assign out_c = out_q;

endmodule

// File: rtl/denoise_temporal_core.sv
// Temporal denoise core: joins previous/current frame AXI streams, runs a
// 3-stage per-channel blend pipeline with per-frame shadowed configuration.
module denoise_temporal_core
    import denoise_pkg::*;
#(
    parameter int CH_WIDTH = CH_WIDTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int ALPHA_W  = ALPHA_W_DEF,
    parameter logic [CHANNELS*CH_WIDTH-1:0] TEST_PATTERN = TEST_PATTERN_DEF
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [1:0]                   cfg_mode,
    input  logic [ALPHA_W-1:0]           cfg_alpha,
    input  logic [CH_WIDTH-1:0]          cfg_thresh,
    input  logic [CHANNELS*CH_WIDTH-1:0] s_prev_axis_tdata,
    input  logic                         s_prev_axis_tvalid,
    output logic                         s_prev_axis_tready,
    input  logic                         s_prev_axis_tlast,
    input  logic                         s_prev_axis_tuser,
    input  logic [CHANNELS*CH_WIDTH-1:0] s_curr_axis_tdata,
    input  logic                         s_curr_axis_tvalid,
    output logic                         s_curr_axis_tready,
    input  logic                         s_curr_axis_tlast,
    input  logic                         s_curr_axis_tuser,
    output logic [CHANNELS*CH_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    output logic                         sync_err,
    input  logic                         err_clear
);

    localparam int DW = CHANNELS * CH_WIDTH;

    logic                en1, en2, en3, pipe_en, join_hs, new_frame, ld2, ld3;
    logic                v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    logic [DW-1:0]       prev1_d, prev1_q, curr1_d, curr1_q;
    logic                last1_d, last1_q, user1_d, user1_q;
    logic                last2_d, last2_q, user2_d, user2_q;
    logic                last3_d, last3_q, user3_d, user3_q;
    mode_e               mode_sh_d, mode_sh_q, mode1_d, mode1_q, mode2_d, mode2_q;
    logic [ALPHA_W-1:0]  alpha_sh_d, alpha_sh_q, alpha1_d, alpha1_q, alpha2_d, alpha2_q;
    logic [CH_WIDTH-1:0] thresh_sh_d, thresh_sh_q, thresh1_d, thresh1_q;
    logic                sync_err_d, sync_err_q;
    logic [CH_WIDTH-1:0] ch_out [CHANNELS];

    always_comb begin
        // A stage may load when it is empty or the stage after it moves.
        en3     = !v3_q || m_axis_tready;
        en2     = !v2_q || en3;
        en1     = !v1_q || en2;
        pipe_en = en1 && !areset;

        s_prev_axis_tready = s_curr_axis_tvalid && pipe_en;
        s_curr_axis_tready = s_prev_axis_tvalid && pipe_en;
        join_hs   = s_prev_axis_tvalid && s_curr_axis_tvalid && pipe_en;
        new_frame = join_hs && s_curr_axis_tuser;
        ld2       = en2 && v1_q;
        ld3       = en3 && v2_q;

        // The frame-start beat already uses the newly latched configuration.
        mode_sh_d   = new_frame ? mode_e'(cfg_mode) : mode_sh_q;
        alpha_sh_d  = new_frame ? cfg_alpha : alpha_sh_q;
        thresh_sh_d = new_frame ? cfg_thresh : thresh_sh_q;

        v1_d      = en1 ? join_hs : v1_q;
        prev1_d   = join_hs ? s_prev_axis_tdata : prev1_q;
        curr1_d   = join_hs ? s_curr_axis_tdata : curr1_q;
        last1_d   = join_hs ? s_curr_axis_tlast : last1_q;
        user1_d   = join_hs ? s_curr_axis_tuser : user1_q;
        mode1_d   = join_hs ? mode_sh_d : mode1_q;
        alpha1_d  = join_hs ? alpha_sh_d : alpha1_q;
        thresh1_d = join_hs ? thresh_sh_d : thresh1_q;

        v2_d     = en2 ? v1_q : v2_q;
        last2_d  = ld2 ? last1_q : last2_q;
        user2_d  = ld2 ? user1_q : user2_q;
        mode2_d  = ld2 ? mode1_q : mode2_q;
        alpha2_d = ld2 ? alpha1_q : alpha2_q;

        v3_d    = en3 ? v2_q : v3_q;
        last3_d = ld3 ? last2_q : last3_q;
        user3_d = ld3 ? user2_q : user3_q;

        sync_err_d = sync_err_q;
        if (err_clear) begin
            sync_err_d = 1'b0;
        end
        if (join_hs && ((s_prev_axis_tuser != s_curr_axis_tuser) ||
                        (s_prev_axis_tlast != s_curr_axis_tlast))) begin
            sync_err_d = 1'b1;
        end

        m_axis_tdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            m_axis_tdata[c*CH_WIDTH +: CH_WIDTH] = ch_out[c];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            prev1_q     <= '0;
            curr1_q     <= '0;
            last1_q     <= 1'b0;
            user1_q     <= 1'b0;
            last2_q     <= 1'b0;
            user2_q     <= 1'b0;
            last3_q     <= 1'b0;
            user3_q     <= 1'b0;
            mode_sh_q   <= MODE_PASS;
            alpha_sh_q  <= '0;
            thresh_sh_q <= '0;
            mode1_q     <= MODE_PASS;
            alpha1_q    <= '0;
            thresh1_q   <= '0;
            mode2_q     <= MODE_PASS;
            alpha2_q    <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            prev1_q     <= prev1_d;
            curr1_q     <= curr1_d;
            last1_q     <= last1_d;
            user1_q     <= user1_d;
            last2_q     <= last2_d;
            user2_q     <= user2_d;
            last3_q     <= last3_d;
            user3_q     <= user3_d;
            mode_sh_q   <= mode_sh_d;
            alpha_sh_q  <= alpha_sh_d;
            thresh_sh_q <= thresh_sh_d;
            mode1_q     <= mode1_d;
            alpha1_q    <= alpha1_d;
            thresh1_q   <= thresh1_d;
            mode2_q     <= mode2_d;
            alpha2_q    <= alpha2_d;
            sync_err_q  <= sync_err_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        denoise_blend_ch #(
            .CH_WIDTH (CH_WIDTH),
            .ALPHA_W  (ALPHA_W)
        ) u_ch (
            .aclk   (aclk),
            .areset (areset),
            .ld2    (ld2),
            .ld3    (ld3),
            .prev_c (prev1_q[c*CH_WIDTH +: CH_WIDTH]),
            .curr_c (curr1_q[c*CH_WIDTH +: CH_WIDTH]),
            .thresh (thresh1_q),
            .pat_c  (TEST_PATTERN[c*CH_WIDTH +: CH_WIDTH]),
            .mode   (mode2_q),
            .alpha  (alpha2_q),
            .out_c  (ch_out[c])
        );
    end

    assign m_axis_tvalid = v3_q;
    assign m_axis_tlast  = last3_q;
    assign m_axis_tuser  = user3_q;
    assign sync_err      = sync_err_q;

endmodule

// File: doc/denoise_temporal_core.md
DENOISE_TEMPORAL_CORE -- requirements
Module: denoise_temporal_core

Interface
REQ-001 SHALL have parameter CH_WIDTH, default 8, bits per colour channel.
REQ-002 SHALL have parameter CHANNELS, default 3, channels per beat; DATA_WIDTH = CHANNELS*CH_WIDTH.
REQ-003 SHALL have parameter ALPHA_W, default 4, blend-weight width.
REQ-004 SHALL have parameter TEST_PATTERN, default 24'hFF0000 (width DATA_WIDTH), mode-0 constant.
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 areset  in  1  synchronous, active-high reset.
REQ-007 cfg_mode  in  2  00 test pattern, 01 pass curr, 10 temporal blend, 11 abs-difference view.
REQ-008 cfg_alpha  in  ALPHA_W  weight of prev pixel in blend.
REQ-009 cfg_thresh  in  CH_WIDTH  per-channel motion threshold.
REQ-010 s_prev_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  previous-frame stream.
REQ-011 s_curr_axis_tdata/tvalid/tready/tlast/tuser  same  current-frame stream.
REQ-012 m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/1  result stream.
REQ-013 sync_err  out  1  sticky: prev/curr tuser or tlast mismatch on a joined beat.
REQ-014 err_clear  in  1  single-cycle clear of sync_err.

Function
REQ-015 Join: beat accepted only when both tvalid high and pipe_en high; s_prev_axis_tready = s_curr_axis_tvalid & pipe_en, s_curr_axis_tready = s_prev_axis_tvalid & pipe_en; no tready depends on its own tvalid.
REQ-016 pipe_en = !m_axis_tvalid | m_axis_tready | any pipeline bubble ahead; stall holds every stage, no beat dropped or duplicated.
REQ-017 Pipeline 3 stages: S1 register inputs, S2 per-channel diff/compare, S3 blend/select into output register; latency 3 cycles accept-to-m_axis_tvalid with tready high.
REQ-018 Full throughput: one beat per cycle when both inputs valid and m_axis_tready high.
REQ-019 cfg_mode, cfg_alpha, cfg_thresh latched into shadow registers on a joined beat with curr tuser=1, and used for that beat and rest of frame; mid-frame changes ignored.
REQ-020 Mode 00: tdata = TEST_PATTERN. Mode 01: tdata = curr.
REQ-021 Mode 10, per channel c: d = prev_c - curr_c (signed CH_WIDTH+1); if |d| > thresh, out_c = curr_c; else out_c = curr_c + ((d*alpha) >>> ALPHA_W), arithmetic shift toward minus infinity, clamped to [0, 2^CH_WIDTH-1].
REQ-022 Mode 11, per channel: out_c = |prev_c - curr_c| saturated to CH_WIDTH bits.
REQ-023 alpha=0 in mode 10 SHALL equal mode 01 output exactly.
REQ-024 m_axis_tlast/tuser SHALL be curr tlast/tuser, delayed in lockstep with tdata.
REQ-025 sync_err set on joined beat where prev tuser != curr tuser or prev tlast != curr tlast; set has priority over err_clear in same cycle; beat still forwarded.
REQ-026 m_axis_tdata/tlast/tuser stable while m_axis_tvalid high and m_axis_tready low.

Reset
REQ-027 On areset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, sync_err=0, all stage valids=0, shadow config = mode 01, alpha 0, thresh 0.
REQ-028 Both s_*_tready SHALL be 0 while areset high; beats in flight at reset discarded.
REQ-029 First joined beat after reset SHALL use shadow config until next curr tuser=1.

Structure
REQ-030 Shared package denoise_pkg SHALL hold mode encodings, default CH_WIDTH/CHANNELS/ALPHA_W and TEST_PATTERN.
REQ-031 Per-channel arithmetic SHALL be sub-module denoise_blend_ch (S2/S3 datapath for one channel), instantiated CHANNELS times by generate.

Verification
REQ-032 Mode 10, alpha=8, thresh=32, prev=0x404040, curr=0x202020 (tuser=1) -> out 0x303030 after 3 cycles.
REQ-033 Mode 10, thresh=16, prev=0x808080, curr=0x202020 -> out 0x202020 (motion bypass); mode 11 same data -> 0x606060.
REQ-034 Random m_axis_tready (50%) and independent input valids over 1000 beats -> output equals reference model sequence, no loss/duplication, data stable while stalled.
REQ-035 cfg_mode changed 00->01 mid-frame -> output stays TEST_PATTERN until next tuser=1 beat, then passes curr.
REQ-036 prev tuser=0, curr tuser=1 on one beat -> sync_err=1 and remains; err_clear pulse -> 0; simultaneous mismatch and err_clear -> stays 1.
REQ-037 areset asserted with 2 beats in pipeline and m_axis_tready low -> next cycle m_axis_tvalid=0, sync_err=0, both s_*_tready=0 while reset high.
